syscall_controller: RTL and testbench
=====================================

SYSCALL_CONTROLLER -- requirements
Module: syscall_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of syscall argument and output data; SHALL be >= 32.
REQ-002 Parameter FIFO_DEPTH, default 4: output queue entries; SHALL be a power of two, >= 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 is_syscall  input  1  execute stage presents a syscall this cycle.
REQ-006 syscall_funct  input  32  syscall number ($v0).
REQ-007 syscall_param1  input  DATA_WIDTH  first argument ($a0).
REQ-008 stall  output  1  syscall not accepted; pipeline SHALL hold its inputs.
REQ-009 out_valid  output  1  output record available.
REQ-010 out_ready  input  1  consumer accepts record.
REQ-011 out_kind  output  2  record type: 0 = int, 1 = char.
REQ-012 out_data  output  DATA_WIDTH  record payload.
REQ-013 halted  output  1  program has exited and all output has drained.
REQ-014 exit_code  output  32  exit status.
REQ-015 bad_syscall  output  1  sticky: an unsupported number was seen.
REQ-016 bad_count  output  8  count of unsupported syscalls, saturating at 255.

Function
REQ-017 Accepted syscall SHALL be defined as is_syscall=1 and stall=0 in the same cycle.
REQ-018 Supported numbers SHALL be PRINT_INT=1, EXIT=10, PRINT_CHAR=11, EXIT2=17.
REQ-019 Accepted PRINT_INT SHALL push a record {kind 0, syscall_param1} into the FIFO.
REQ-020 Accepted PRINT_CHAR SHALL push a record {kind 1, zero-extended syscall_param1[7:0]}.
REQ-021 Accepted EXIT SHALL set exit_code=0; accepted EXIT2 SHALL set exit_code=syscall_param1[31:0]; both SHALL move the FSM RUN->DRAIN.
REQ-022 Accepted unsupported number SHALL push nothing, set bad_syscall, and increment bad_count; state SHALL be unchanged.
REQ-023 FSM states: RUN, DRAIN, HALTED. RUN->DRAIN on an accepted exit. DRAIN->HALTED when the FIFO is empty. HALTED is terminal until reset.
REQ-024 stall SHALL be combinational: is_syscall & (state!=RUN | (FIFO full & number is PRINT_INT or PRINT_CHAR)).
REQ-025 Full SHALL stall even if a pop occurs in the same cycle; exit and unsupported numbers SHALL NOT be stalled by full.
REQ-026 Records SHALL pop on out_valid & out_ready, in FIFO order.
REQ-027 out_valid SHALL equal FIFO not-empty; out_kind and out_data SHALL be the head entry, stable while out_valid & !out_ready.
REQ-028 Latency: a print accepted into an empty FIFO in cycle N SHALL give out_valid=1 in cycle N+1.
REQ-029 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged.
REQ-030 Pointers SHALL wrap modulo FIFO_DEPTH; an occupancy counter of log2(FIFO_DEPTH)+1 bits SHALL distinguish full from empty.
REQ-031 halted SHALL be registered and assert the cycle after the DRAIN->HALTED transition condition holds.
REQ-032 Records SHALL continue to drain in DRAIN; no new pushes SHALL occur in DRAIN or HALTED.

Reset
REQ-033 When rst_n=0 at a clock edge: state=RUN, FIFO empty, out_valid=0, out_kind=0, out_data=0, halted=0, exit_code=0, bad_syscall=0, bad_count=0.
REQ-034 Reset mid-operation SHALL discard all queued records and any pending exit.
REQ-035 stall SHALL read 0 during reset regardless of is_syscall.

Structure
REQ-036 Syscall numbers, out_kind encodings and FSM state encodings SHALL live in the shared syscall defines header, guarded against double inclusion.
REQ-037 The queue SHALL be a sub-module syscall_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, head outputs); the FSM, decode and counters SHALL stay in syscall_controller.

Verification
REQ-038 PRINT_INT param1=-5 with out_ready=1 -> next cycle out_valid=1, out_kind=0, out_data=32'hFFFFFFFB; popped the same cycle.
REQ-039 Five PRINT_CHAR 'A'..'E' back-to-back, DEPTH=4, out_ready=0 -> first four accepted, stall=1 on the fifth until out_ready=1; output order is A,B,C,D,E.
REQ-040 Two PRINT_INT queued, then EXIT2 param1=7 -> no stall on EXIT2; halted=0 until both records pop; then halted=1, exit_code=7; a later is_syscall gives stall=1.
REQ-041 syscall_funct=99, repeated 300 times -> bad_syscall=1, bad_count=255, FIFO empty, state RUN.
REQ-042 rst_n=0 for one cycle with three queued records and state DRAIN -> next cycle out_valid=0, halted=0, state RUN, all REQ-033 values.

Source files
------------

// File: rtl/syscall_controller_pkg.sv
// rtl/syscall_controller_pkg.sv - syscall numbers, record kinds and FSM states
`ifndef SYSCALL_CONTROLLER_PKG_SV
`define SYSCALL_CONTROLLER_PKG_SV
package syscall_controller_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
  localparam logic [31:0] SYS_EXIT2      = 32'd17;

  localparam logic [1:0] KIND_INT  = 2'd0;
  localparam logic [1:0] KIND_CHAR = 2'd1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  function automatic logic is_print(input logic [31:0] funct);
    return (funct == SYS_PRINT_INT) || (funct == SYS_PRINT_CHAR);
  endfunction

  function automatic logic is_exit(input logic [31:0] funct);
    return (funct == SYS_EXIT) || (funct == SYS_EXIT2);
  endfunction

endpackage
`endif

// File: rtl/syscall_fifo.sv
// rtl/syscall_fifo.sv - output record queue with occupancy counter
module syscall_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage is not reset; emptiness is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/syscall_controller.sv
// rtl/syscall_controller.sv - syscall decode, exit FSM and output record stream
module syscall_controller
  import syscall_controller_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  is_syscall,
  input  logic [31:0]           syscall_funct,
  input  logic [DATA_WIDTH-1:0] syscall_param1,
  output logic                  stall,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_kind,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  halted,
  output logic [31:0]           exit_code,
  output logic                  bad_syscall,
  output logic [7:0]            bad_count
);

  localparam int REC_W = DATA_WIDTH + 2;

  state_t           state_q, state_d;
  logic             fifo_full, fifo_empty;
  logic             print_req, exit_req, accept, push;
  logic [REC_W-1:0] push_rec, head_rec;

  assign print_req = is_print(syscall_funct);
  assign exit_req  = is_exit(syscall_funct);

  // Full only blocks prints; a pop in the same cycle does not lift the stall.
  assign stall  = rst_n & is_syscall & ((state_q != ST_RUN) | (fifo_full & print_req));
  assign accept = rst_n & is_syscall & ~stall;
  assign push   = accept & print_req;

  assign push_rec = (syscall_funct == SYS_PRINT_CHAR)
                  ? {KIND_CHAR, {(DATA_WIDTH-8){1'b0}}, syscall_param1[7:0]}
                  : {KIND_INT, syscall_param1};

  syscall_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_rec),
    .pop       (out_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_rec)
  );

  assign out_valid = ~fifo_empty;
  assign out_kind  = out_valid ? head_rec[REC_W-1 -: 2] : 2'd0;
  assign out_data  = out_valid ? head_rec[DATA_WIDTH-1:0] : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (accept && exit_req) state_d = ST_DRAIN;
      ST_DRAIN:  if (fifo_empty) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      halted      <= 1'b0;
      exit_code   <= '0;
      bad_syscall <= 1'b0;
      bad_count   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DRAIN && fifo_empty) begin
        halted <= 1'b1;
      end
      if (accept && exit_req) begin
        exit_code <= (syscall_funct == SYS_EXIT2) ? syscall_param1[31:0] : 32'd0;
      end
      if (accept && !print_req && !exit_req) begin
        bad_syscall <= 1'b1;
        if (bad_count != 8'hFF) bad_count <= bad_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_syscall_controller.sv
// tb/tb_syscall_controller.sv - directed scoreboard bench for syscall_controller
module tb_syscall_controller;
  import syscall_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        is_syscall;
  logic [31:0] syscall_funct;
  logic [31:0] syscall_param1;
  logic        stall;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_kind;
  logic [31:0] out_data;
  logic        halted;
  logic [31:0] exit_code;
  logic        bad_syscall;
  logic [7:0]  bad_count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [33:0] exp_q [$];

  always #5 clk = ~clk;

  syscall_controller #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .is_syscall     (is_syscall),
    .syscall_funct  (syscall_funct),
    .syscall_param1 (syscall_param1),
    .stall          (stall),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_kind       (out_kind),
    .out_data       (out_data),
    .halted         (halted),
    .exit_code      (exit_code),
    .bad_syscall    (bad_syscall),
    .bad_count      (bad_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] funct, input logic [31:0] param);
    is_syscall     = 1'b1;
    syscall_funct  = funct;
    syscall_param1 = param;
  endtask

  // Scoreboard: every handshake must match the oldest expected record.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_record", 64'd1, 64'd0);
      end else begin
        logic [33:0] rec;
        rec = exp_q.pop_front();
        check("out_kind", out_kind, rec[33:32]);
        check("out_data", out_data, rec[31:0]);
      end
    end
  end

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (out_valid === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, out_valid, 1'b0);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; out_ready = 1'b0;
    issue(SYS_PRINT_INT, 32'd0);
    @(negedge clk);
    check("stall_in_reset", stall, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_kind", out_kind, 2'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_halted", halted, 1'b0);
    check("rst_exit_code", exit_code, 32'd0);
    check("rst_bad_syscall", bad_syscall, 1'b0);
    check("rst_bad_count", bad_count, 8'd0);
    check("rst_state", dut.state_q, ST_RUN);
    cycle();
    rst_n = 1'b1; is_syscall = 1'b0;
    cycle();

    // PRINT_INT -5 with the consumer ready
    out_ready = 1'b1;
    issue(SYS_PRINT_INT, 32'hFFFF_FFFB);
    @(negedge clk);
    check("int_stall", stall, 1'b0);
    exp_q.push_back({KIND_INT, 32'hFFFF_FFFB});
    cycle();
    is_syscall = 1'b0;
    @(negedge clk);
    check("int_latency_valid", out_valid, 1'b1);
    cycle();
    @(negedge clk);
    check("int_popped", out_valid, 1'b0);
    cycle();

    // Five chars into a depth-4 queue with the consumer blocked
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue(SYS_PRINT_CHAR, {24'hABCDEF, 8'h41 + 8'(i)});
      @(negedge clk);
      check("char_stall", stall, (i == 4));
      if (i < 4) begin
        exp_q.push_back({KIND_CHAR, 24'h0, 8'h41 + 8'(i)});
        cycle();
      end
    end
    cycle();
    @(negedge clk);
    check("char_full_hold", stall, 1'b1);
    cycle();
    out_ready = 1'b1;
    @(negedge clk);
    check("full_stall_despite_pop", stall, 1'b1);
    cycle();
    @(negedge clk);
    check("char_e_accepted", stall, 1'b0);
    exp_q.push_back({KIND_CHAR, 24'h0, 8'h45});
    cycle();
    is_syscall = 1'b0;
    wait_drain("chars");

    // Two ints queued, then EXIT2 7
    out_ready = 1'b0;
    issue(SYS_PRINT_INT, 32'd100);
    exp_q.push_back({KIND_INT, 32'd100});
    cycle();
    issue(SYS_PRINT_INT, 32'd200);
    exp_q.push_back({KIND_INT, 32'd200});
    cycle();
    issue(SYS_EXIT2, 32'd7);
    @(negedge clk);
    check("exit2_no_stall", stall, 1'b0);
    cycle();
    issue(SYS_PRINT_INT, 32'd300);
    @(negedge clk);
    check("drain_state", dut.state_q, ST_DRAIN);
    check("drain_print_stalled", stall, 1'b1);
    check("drain_not_halted", halted, 1'b0);
    cycle();
    is_syscall = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("halted_while_draining", halted, 1'b0);
    n = 0;
    while (halted !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("halted_set", halted, 1'b1);
    check("exit2_sb_empty", exp_q.size(), 0);
    check("exit2_code", exit_code, 32'd7);
    cycle();
    issue(SYS_PRINT_CHAR, 32'h41);
    @(negedge clk);
    check("halted_stall", stall, 1'b1);
    check("halted_state", dut.state_q, ST_HALTED);
    cycle();

    // Unsupported number 300 times after a reset
    is_syscall = 1'b0; rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("reset_clears_halt", halted, 1'b0);
    check("reset_clears_exit_code", exit_code, 32'd0);
    issue(32'd99, 32'd5);
    @(negedge clk);
    check("bad_no_stall", stall, 1'b0);
    cycle();
    @(negedge clk);
    check("bad_count_one", bad_count, 8'd1);
    repeat (299) cycle();
    is_syscall = 1'b0;
    @(negedge clk);
    check("bad_sticky", bad_syscall, 1'b1);
    check("bad_saturate", bad_count, 8'd255);
    check("bad_no_push", out_valid, 1'b0);
    check("bad_state", dut.state_q, ST_RUN);
    cycle();

    // Reset during DRAIN with three records queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(SYS_PRINT_INT, 32'(i + 1));
      exp_q.push_back({KIND_INT, 32'(i + 1)});
      cycle();
    end
    issue(SYS_EXIT, 32'd9);
    @(negedge clk);
    check("exit_no_stall", stall, 1'b0);
    cycle();
    is_syscall = 1'b0;
    @(negedge clk);
    check("pre_reset_drain", dut.state_q, ST_DRAIN);
    check("exit_code_zero", exit_code, 32'd0);
    cycle();
    rst_n = 1'b0; is_syscall = 1'b1;
    @(negedge clk);
    check("stall_in_mid_reset", stall, 1'b0);
    cycle();
    rst_n = 1'b1; is_syscall = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_halted", halted, 1'b0);
    check("mid_rst_state", dut.state_q, ST_RUN);
    check("mid_rst_out_kind", out_kind, 2'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    check("mid_rst_exit_code", exit_code, 32'd0);
    check("mid_rst_bad_syscall", bad_syscall, 1'b0);
    check("mid_rst_bad_count", bad_count, 8'd0);
    cycle();
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_nothing_queued", out_valid, 1'b0);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
